// File: rtl/spi_obi_bridge_if.sv
// OBI manager-side bus bundle used between spi_obi_bridge and the on-chip fabric.
`timescale 1ns/1ps
interface spi_obi_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Address phase: req/gnt handshake, transfer when both are high on a clock edge;
  // addr/wdata/we/be stay stable while req is high. Response phase: rvalid, no back-pressure.
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, addr, wdata, we, be, input gnt, rvalid, rdata);
  modport slave  (input req, addr, wdata, we, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/spi_obi_bridge.sv
// SPI mode-0 slave that decodes WRITE/READ command frames into single-word OBI
// manager accesses; the SPI front end and the OBI FSM run independently.
`timescale 1ns/1ps
module spi_obi_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_BITS  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_ss_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  spi_obi_bridge_if.master      obi,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [2:0]            dbg_spi_state_o,
  output logic [1:0]            dbg_obi_state_o
);
  localparam int SHW    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNTMAX = (SHW > DUMMY_BITS) ? SHW : DUMMY_BITS;
  localparam int CNT_W  = $clog2(CNTMAX + 1);
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [DATA_WIDTH-1:0] BAD_WORD = {(DATA_WIDTH/16){16'hBAD0}};

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_DISCARD} spi_state_t;
  typedef enum logic [1:0] {O_IDLE, O_REQ, O_RESP} obi_state_t;

  spi_state_t r_spi_state, w_spi_next;
  obi_state_t r_obi_state, w_obi_next;

  logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
  logic                   r_ss_d, r_sclk_d;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [SHW-1:0]         r_shift;
  logic [7:0]             r_cmd;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_miso_sr, r_rbuf;
  logic                   r_rbuf_valid, r_rd_want, r_err;
  logic [ADDR_WIDTH-1:0]  r_obi_addr;
  logic [DATA_WIDTH-1:0]  r_obi_wdata;
  logic                   r_obi_we;
  logic [DATA_WIDTH/8-1:0] r_obi_be;

  logic w_ss, w_sclk, w_mosi, w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
  logic w_launch_rd, w_launch_wr, w_launch, w_obi_idle, w_drop, w_bad_cmd, w_load_miso, w_underrun;
  logic [SHW-1:0] w_shift_next;
  logic [7:0]     w_cmd_byte;

  // SS resets high so leaving reset never looks like a frame start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ss_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_i};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_ss_d      <= w_ss;
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_ss         = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_fall    = r_ss_d & ~w_ss;
  assign w_ss_rise    = ~r_ss_d & w_ss;
  assign w_sclk_rise  = ~r_sclk_d & w_sclk;
  assign w_sclk_fall  = r_sclk_d & ~w_sclk;
  assign w_shift_next = {r_shift[SHW-2:0], w_mosi};
  assign w_cmd_byte   = w_shift_next[7:0];

  always_comb begin
    w_spi_next  = r_spi_state;
    w_launch_rd = 1'b0;
    w_launch_wr = 1'b0;
    w_bad_cmd   = 1'b0;
    w_load_miso = 1'b0;
    if (w_ss_rise) begin
      w_spi_next = S_IDLE;
    end else if (w_ss_fall) begin
      w_spi_next = S_CMD;
    end else begin
      case (r_spi_state)
        S_CMD: if (w_sclk_rise && r_bit_cnt == CNT_W'(7)) begin
          if (w_cmd_byte == CMD_WRITE || w_cmd_byte == CMD_READ) w_spi_next = S_ADDR;
          else begin
            w_spi_next = S_DISCARD;
            w_bad_cmd  = 1'b1;
          end
        end
        S_ADDR: if (w_sclk_rise && r_bit_cnt == CNT_W'(ADDR_WIDTH-1)) begin
          if (r_cmd == CMD_WRITE) w_spi_next = S_WDATA;
          else begin
            w_spi_next  = S_DUMMY;
            w_launch_rd = 1'b1;
          end
        end
        S_WDATA: if (w_sclk_rise && r_bit_cnt == CNT_W'(DATA_WIDTH-1)) begin
          w_spi_next  = S_IDLE;
          w_launch_wr = 1'b1;
        end
        // The fall after the last dummy sample is where the first data bit must appear.
        S_DUMMY: if (w_sclk_fall && r_bit_cnt == CNT_W'(DUMMY_BITS)) begin
          w_spi_next  = S_RDATA;
          w_load_miso = 1'b1;
        end
        S_RDATA: if (w_sclk_rise && r_bit_cnt == CNT_W'(DATA_WIDTH-1)) w_spi_next = S_IDLE;
        default: ;
      endcase
    end
  end

  assign w_launch   = w_launch_rd | w_launch_wr;
  assign w_obi_idle = (r_obi_state == O_IDLE);
  assign w_drop     = w_launch & ~w_obi_idle;
  assign w_underrun = w_load_miso & ~r_rbuf_valid;

  always_comb begin
    w_obi_next = r_obi_state;
    case (r_obi_state)
      O_IDLE:  if (w_launch)   w_obi_next = O_REQ;
      O_REQ:   if (obi.gnt)    w_obi_next = O_RESP;
      O_RESP:  if (obi.rvalid) w_obi_next = O_IDLE;
      default: w_obi_next = O_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_spi_state <= S_IDLE;
      r_obi_state <= O_IDLE;
    end else begin
      r_spi_state <= w_spi_next;
      r_obi_state <= w_obi_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_miso_sr    <= '0;
      r_rbuf       <= '0;
      r_rbuf_valid <= 1'b0;
      r_rd_want    <= 1'b0;
      r_err        <= 1'b0;
      r_obi_addr   <= '0;
      r_obi_wdata  <= '0;
      r_obi_we     <= 1'b0;
      r_obi_be     <= '0;
    end else begin
      r_err <= w_bad_cmd | w_drop | w_underrun;
      if (w_spi_next != r_spi_state || w_ss_fall) r_bit_cnt <= '0;
      else if (w_sclk_rise && r_spi_state != S_IDLE && r_spi_state != S_DISCARD) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_sclk_rise && (r_spi_state == S_CMD || r_spi_state == S_ADDR || r_spi_state == S_WDATA))
        r_shift <= w_shift_next;
      if (r_spi_state == S_CMD && w_spi_next == S_ADDR) r_cmd <= w_cmd_byte;
      if (r_spi_state == S_ADDR && w_spi_next == S_WDATA) r_addr <= w_shift_next[ADDR_WIDTH-1:0];
      if (w_load_miso) r_miso_sr <= r_rbuf_valid ? r_rbuf : BAD_WORD;
      else if (r_spi_state == S_RDATA && w_sclk_fall) r_miso_sr <= {r_miso_sr[DATA_WIDTH-2:0], 1'b0};
      // r_rd_want marks whether the in-flight read still has a frame waiting for it.
      if (w_ss_fall) r_rbuf_valid <= 1'b0;
      if (w_launch_rd) begin
        r_rbuf_valid <= 1'b0;
        r_rd_want    <= w_obi_idle;
      end else if (w_ss_rise || w_underrun) begin
        r_rd_want <= 1'b0;
      end else if (r_obi_state == O_RESP && obi.rvalid && !r_obi_we) begin
        if (r_rd_want) begin
          r_rbuf       <= obi.rdata;
          r_rbuf_valid <= 1'b1;
        end
        r_rd_want <= 1'b0;
      end
      if (w_launch && w_obi_idle) begin
        r_obi_addr  <= w_launch_rd ? w_shift_next[ADDR_WIDTH-1:0] : r_addr;
        r_obi_wdata <= w_launch_wr ? w_shift_next[DATA_WIDTH-1:0] : '0;
        r_obi_we    <= w_launch_wr;
        r_obi_be    <= '1;
      end
    end
  end

  assign obi.req         = (r_obi_state == O_REQ);
  assign obi.addr        = r_obi_addr;
  assign obi.wdata       = r_obi_wdata;
  assign obi.we          = r_obi_we;
  assign obi.be          = r_obi_be;
  assign busy_o          = ~w_obi_idle;
  assign err_o           = r_err;
  assign spi_miso_o      = (r_spi_state == S_RDATA) & r_miso_sr[DATA_WIDTH-1];
  assign dbg_spi_state_o = r_spi_state;
  assign dbg_obi_state_o = r_obi_state;
endmodule
